// File: rtl/lut_interp_reader_pkg.sv
// Shared constants for the interpolating table reader: output FIFO depth and
// the rounding offset used when dropping fractional bits.
package lut_interp_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 4;

  // Half an LSB of the fractional product; adding it before the arithmetic
  // shift rounds half toward +inf.
  function automatic int unsigned round_const(input int unsigned frac_width);
    return 1 << (frac_width - 1);
  endfunction

endpackage

// File: rtl/lut_interp_reader_sync_fifo.sv
// Small register FIFO with occupancy count; head entry is visible while
// head_valid is high and leaves on pop.
module sync_fifo_small #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (cnt != '0);
  assign do_push = push & ((cnt != FULL) | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/lut_interp_reader.sv
// Fixed-point table lookup with linear interpolation between two adjacent
// entries read through the container's dual ports; results leave in order.
module lut_interp_reader
  import lut_interp_reader_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH    = 8,
  parameter int unsigned C_ADDRESS_WIDTH = 8,
  parameter int unsigned C_FRAC_WIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [C_ADDRESS_WIDTH+C_FRAC_WIDTH-1:0] s_index,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [C_DATA_WIDTH-1:0]               m_data,
  output logic                                  dropped,
  input  logic                                  tbl_load,
  input  logic [C_ADDRESS_WIDTH:0]              size,
  output logic [C_ADDRESS_WIDTH-1:0]            addrA,
  input  logic [C_DATA_WIDTH-1:0]               qA,
  output logic [C_ADDRESS_WIDTH-1:0]            addrB,
  input  logic [C_DATA_WIDTH-1:0]               qB
);

  localparam int unsigned DW = C_DATA_WIDTH;
  localparam int unsigned AW = C_ADDRESS_WIDTH;
  localparam int unsigned FW = C_FRAC_WIDTH;
  localparam int unsigned PW = DW + FW + 2;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [PW-1:0] RND     = PW'(round_const(FW));
  localparam logic [CW-1:0]        CREDITS = CW'(FIFO_DEPTH);

  logic [AW-1:0] idx_int;
  logic [FW-1:0] idx_frac;
  logic [AW-1:0] lim;
  logic [AW-1:0] next_a;
  logic [AW-1:0] next_b;
  logic          accept;

  logic          p0_valid;
  logic [FW-1:0] p0_frac;
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;
  logic          p1_valid;
  logic [FW-1:0] p1_frac;
  logic          dropped_q;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic [DW-1:0]        interp;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic          fifo_pop;

  assign idx_int  = s_index[FW +: AW];
  assign idx_frac = s_index[FW-1:0];
  assign lim      = AW'(size - (C_ADDRESS_WIDTH + 1)'(1));

  // Clamp at the last valid entry instead of wrapping to entry 0.
  always_comb begin
    next_a = idx_int;
    next_b = idx_int + AW'(1);
    if (idx_int >= lim) begin
      next_a = lim;
      next_b = lim;
    end
  end

  // The FIFO slot is the P2 result register, so its count covers P2.
  assign occupancy = fifo_count + CW'(p0_valid) + CW'(p1_valid);
  assign s_ready   = ~reset & ~tbl_load & (occupancy < CREDITS);
  assign accept    = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_valid <= 1'b0;
      p0_frac  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      p0_valid <= accept;
      if (accept) begin
        p0_frac  <= idx_frac;
        addr_a_q <= next_a;
        addr_b_q <= next_b;
      end
    end
  end

  // A port-A write during the read cycle corrupts qA: discard that item.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid  <= 1'b0;
      p1_frac   <= '0;
      dropped_q <= 1'b0;
    end else begin
      p1_valid  <= p0_valid & ~tbl_load;
      p1_frac   <= p0_frac;
      dropped_q <= p0_valid & tbl_load;
    end
  end

  always_comb begin
    diff    = $signed({1'b0, qB}) - $signed({1'b0, qA});
    prod    = PW'(diff) * PW'($signed({1'b0, p1_frac}));
    shifted = (prod + RND) >>> FW;
    interp  = qA + DW'(shifted);
  end

  assign fifo_pop = m_valid & m_ready;

  sync_fifo_small #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (p1_valid),
    .push_data  (interp),
    .pop        (fifo_pop),
    .head_data  (m_data),
    .head_valid (m_valid),
    .count      (fifo_count)
  );

  assign addrA   = addr_a_q;
  assign addrB   = addr_b_q;
  assign dropped = dropped_q;

endmodule
